// File: rtl/mac_arb_pkg.sv
// Shared types and helpers for the MAC round-robin arbiter.
// Operand bundle layout and tag width helper.
package mac_arb_pkg;

  localparam int W  = 16;
  localparam int YW = 32;

  function automatic int tag_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic signed [W-1:0] c;
    logic signed [W-1:0] d;
    logic signed [W-1:0] e;
  } operand_t;

endpackage

// File: rtl/mac_rr_arbiter_rr.sv
// Combinational round-robin grant: first requester after ptr_i,
// wrapping modulo NREQ. Reusable for any shared resource.
module rr_arbiter
  import mac_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int TW   = tag_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [TW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [TW-1:0]   idx_o
);

  int   j;
  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = TW'(j);
      end
    end
  end

endmodule

// File: rtl/mac_rr_arbiter.sv
// Shares one 1-cycle MAC among NREQ requesters; the tag register
// tracks which requester owns the result currently held by the MAC.
module mac_rr_arbiter
#(
  parameter int NREQ = 4,
  parameter int W    = mac_arb_pkg::W,
  parameter int YW   = mac_arb_pkg::YW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*W-1:0] req_c,
  input  logic [NREQ*W-1:0] req_d,
  input  logic [NREQ*W-1:0] req_e,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [YW-1:0]     resp_y,
  output logic              mac_in_valid,
  input  logic              mac_in_ready,
  output logic [W-1:0]      mac_a,
  output logic [W-1:0]      mac_b,
  output logic [W-1:0]      mac_c,
  output logic [W-1:0]      mac_d,
  output logic [W-1:0]      mac_e,
  input  logic              mac_out_valid,
  output logic              mac_out_ready,
  input  logic [YW-1:0]     mac_y
);

  import mac_arb_pkg::*;

  localparam int TW = tag_w(NREQ);

  logic [TW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]   tag_q, tag_d;
  logic [NREQ-1:0] grant;
  logic [TW-1:0]   gidx;
  logic            any_grant;
  logic            issue;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (gidx)
  );

  assign any_grant    = |grant;
  assign mac_in_valid = |req_valid;
  assign req_ready    = grant & {NREQ{mac_in_ready}};
  assign issue        = mac_in_valid & mac_in_ready;

  always_comb begin
    mac_a = '0;
    mac_b = '0;
    mac_c = '0;
    mac_d = '0;
    mac_e = '0;
    if (any_grant) begin
      mac_a = req_a[int'(gidx)*W +: W];
      mac_b = req_b[int'(gidx)*W +: W];
      mac_c = req_c[int'(gidx)*W +: W];
      mac_d = req_d[int'(gidx)*W +: W];
      mac_e = req_e[int'(gidx)*W +: W];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    tag_d    = tag_q;
    if (issue) begin
      rr_ptr_d = gidx;
      tag_d    = gidx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= TW'(NREQ - 1);
      tag_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tag_q    <= tag_d;
    end
  end

  // Tag moves on the same edge the MAC loads, so it always names mac_y's owner.
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++)
      resp_valid[i] = mac_out_valid & (tag_q == TW'(i));
  end

  assign resp_y        = mac_y;
  assign mac_out_ready = resp_ready[tag_q];

endmodule

// File: tb/tb_mac_rr_arbiter.sv
// Bench for mac_rr_arbiter: directed table, then random traffic
// against a cycle-level reference model with a 1-cycle MAC.
module tb_mac_rr_arbiter;
  import mac_arb_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [N*16-1:0] req_a, req_b, req_c, req_d, req_e;
  logic [31:0]     resp_y, mac_y;
  logic            mac_in_valid, mac_in_ready;
  logic            mac_out_valid, mac_out_ready;
  logic [15:0]     mac_a, mac_b, mac_c, mac_d, mac_e;
  operand_t        ops [N];

  mac_rr_arbiter #(.NREQ(N), .W(16), .YW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_c         (req_c),
    .req_d         (req_d),
    .req_e         (req_e),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_y        (resp_y),
    .mac_in_valid  (mac_in_valid),
    .mac_in_ready  (mac_in_ready),
    .mac_a         (mac_a),
    .mac_b         (mac_b),
    .mac_c         (mac_c),
    .mac_d         (mac_d),
    .mac_e         (mac_e),
    .mac_out_valid (mac_out_valid),
    .mac_out_ready (mac_out_ready),
    .mac_y         (mac_y)
  );

  always_comb begin
    req_a = '0;
    req_b = '0;
    req_c = '0;
    req_d = '0;
    req_e = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*16 +: 16] = ops[i].a;
      req_b[i*16 +: 16] = ops[i].b;
      req_c[i*16 +: 16] = ops[i].c;
      req_d[i*16 +: 16] = ops[i].d;
      req_e[i*16 +: 16] = ops[i].e;
    end
  end

  function automatic logic [31:0] mac_f(
    logic signed [15:0] a, logic signed [15:0] b,
    logic signed [15:0] c, logic signed [15:0] d,
    logic signed [15:0] e);
    logic signed [63:0] r;
    r = 64'(a) * 64'(b) + 64'(c) * 64'(d) + 64'(e);
    return r[31:0];
  endfunction

  // Single-stage MAC environment with in_ready = ~out_valid | out_ready.
  logic        mv;
  logic [31:0] my;
  assign mac_out_valid = mv;
  assign mac_y         = my;
  assign mac_in_ready  = !mv || mac_out_ready;

  always @(posedge clk) begin
    if (rst) mv <= 1'b0;
    else if (mac_in_valid && mac_in_ready) begin
      mv <= 1'b1;
      my <= mac_f(mac_a, mac_b, mac_c, mac_d, mac_e);
    end else if (mac_out_ready) mv <= 1'b0;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [3:0]  rr;
    operand_t    op;
    logic [3:0]  e_rdy;
    logic [3:0]  e_rv;
    logic [31:0] e_y;
  } row_t;

  row_t rows[$];

  function automatic operand_t opr(int a, int b, int c, int d, int e);
    operand_t o;
    o.a = 16'(a); o.b = 16'(b); o.c = 16'(c);
    o.d = 16'(d); o.e = 16'(e);
    return o;
  endfunction

  function automatic row_t mk(logic r, logic [3:0] rv, logic [3:0] rr,
    operand_t op, logic [3:0] e_rdy, logic [3:0] e_rv, logic [31:0] e_y);
    row_t x;
    x.rst = r; x.rv = rv; x.rr = rr; x.op = op;
    x.e_rdy = e_rdy; x.e_rv = e_rv; x.e_y = e_y;
    return x;
  endfunction

  int          m_ptr, m_tag, g, acc;
  logic        m_vld, inr;
  logic [31:0] m_y;
  logic [3:0]  e_rdy, e_rv;

  initial begin
    operand_t o1, o2, o3, ox, z;
    o1 = opr(3, 4, 5, 6, 7);
    o2 = opr(2, 3, 4, 5, 6);
    o3 = opr(-2, 3, 0, 0, 1);
    ox = opr(-32768, -32768, -32768, -32768, -32768);
    z  = opr(0, 0, 0, 0, 0);
    // reset state, then lone requester 2
    rows.push_back(mk(0, 4'b0000, 4'b0000, z,  4'b0000, 4'b0000, 0));
    rows.push_back(mk(0, 4'b0100, 4'b1111, o1, 4'b0100, 4'b0000, 0));
    rows.push_back(mk(0, 4'b0000, 4'b1111, o1, 4'b0000, 4'b0100, 49));
    // all four requesting: 0,1,2,3,0
    rows.push_back(mk(1, 4'b0000, 4'b1111, o2, 4'b0000, 4'b0000, 0));
    rows.push_back(mk(0, 4'b1111, 4'b1111, o2, 4'b0001, 4'b0000, 0));
    rows.push_back(mk(0, 4'b1111, 4'b1111, o2, 4'b0010, 4'b0001, 32));
    rows.push_back(mk(0, 4'b1111, 4'b1111, o2, 4'b0100, 4'b0010, 32));
    rows.push_back(mk(0, 4'b1111, 4'b1111, o2, 4'b1000, 4'b0100, 32));
    rows.push_back(mk(0, 4'b1111, 4'b1111, o2, 4'b0001, 4'b1000, 32));
    rows.push_back(mk(0, 4'b0000, 4'b1111, o2, 4'b0000, 4'b0001, 32));
    rows.push_back(mk(0, 4'b0000, 4'b1111, o2, 4'b0000, 4'b0000, 0));
    // response stall on port 0 while req 1 waits
    rows.push_back(mk(0, 4'b0001, 4'b1111, o3, 4'b0001, 4'b0000, 0));
    rows.push_back(mk(0, 4'b0010, 4'b1110, o3, 4'b0000, 4'b0001, 32'hFFFFFFFB));
    rows.push_back(mk(0, 4'b0010, 4'b1110, o3, 4'b0000, 4'b0001, 32'hFFFFFFFB));
    rows.push_back(mk(0, 4'b0010, 4'b1110, o3, 4'b0000, 4'b0001, 32'hFFFFFFFB));
    rows.push_back(mk(0, 4'b0010, 4'b1111, o3, 4'b0010, 4'b0001, 32'hFFFFFFFB));
    rows.push_back(mk(0, 4'b0000, 4'b1111, o3, 4'b0000, 4'b0010, 32'hFFFFFFFB));
    // wrap-around: ptr=1, req 3 before req 1
    rows.push_back(mk(0, 4'b1010, 4'b1111, o1, 4'b1000, 4'b0000, 0));
    rows.push_back(mk(0, 4'b0010, 4'b1111, o1, 4'b0010, 4'b1000, 49));
    rows.push_back(mk(0, 4'b0000, 4'b1111, o1, 4'b0000, 4'b0010, 49));
    // extreme operands
    rows.push_back(mk(0, 4'b0001, 4'b1111, ox, 4'b0001, 4'b0000, 0));
    rows.push_back(mk(0, 4'b0000, 4'b1111, ox, 4'b0000, 4'b0001, 32'd2147450880));
    // reset while port 2 result pending
    rows.push_back(mk(0, 4'b0100, 4'b0000, o1, 4'b0100, 4'b0000, 0));
    rows.push_back(mk(1, 4'b0000, 4'b0000, o1, 4'b0000, 4'b0100, 49));
    rows.push_back(mk(0, 4'b1111, 4'b1111, o1, 4'b0001, 4'b0000, 0));
    rows.push_back(mk(0, 4'b0000, 4'b1111, o1, 4'b0000, 4'b0001, 49));
    // single requester re-granted every cycle
    rows.push_back(mk(0, 4'b0100, 4'b1111, o1, 4'b0100, 4'b0000, 0));
    rows.push_back(mk(0, 4'b0100, 4'b1111, o1, 4'b0100, 4'b0100, 49));
    rows.push_back(mk(0, 4'b0000, 4'b1111, o1, 4'b0000, 4'b0100, 49));

    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    for (int i = 0; i < N; i++) ops[i] = z;
    repeat (2) @(posedge clk);
    #1;

    foreach (rows[k]) begin
      rst        = rows[k].rst;
      req_valid  = rows[k].rv;
      resp_ready = rows[k].rr;
      for (int i = 0; i < N; i++) ops[i] = rows[k].op;
      @(negedge clk);
      chk($sformatf("row%0d req_ready", k), 128'(req_ready), 128'(rows[k].e_rdy));
      chk($sformatf("row%0d resp_valid", k), 128'(resp_valid), 128'(rows[k].e_rv));
      if (rows[k].e_rv != 0)
        chk($sformatf("row%0d resp_y", k), 128'(resp_y), 128'(rows[k].e_y));
      @(posedge clk);
      #1;
    end

    // randomized traffic against the reference model
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_ptr = N - 1;
    m_tag = 0;
    m_vld = 1'b0;
    m_y   = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          req_valid[i] = 1'b1;
          ops[i] = opr($urandom, $urandom, $urandom, $urandom, $urandom);
        end
        resp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      inr = !m_vld || resp_ready[m_tag];
      g = -1;
      for (int k = 1; k <= N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      e_rdy = (g >= 0 && inr) ? 4'(1 << g) : 4'b0000;
      e_rv  = m_vld ? 4'(1 << m_tag) : 4'b0000;
      chk($sformatf("rnd%0d req_ready", cyc), 128'(req_ready), 128'(e_rdy));
      chk($sformatf("rnd%0d resp_valid", cyc), 128'(resp_valid), 128'(e_rv));
      chk($sformatf("rnd%0d mac_in_valid", cyc), 128'(mac_in_valid), 128'(|req_valid));
      if (m_vld)
        chk($sformatf("rnd%0d resp_y", cyc), 128'(resp_y), 128'(m_y));
      if (g >= 0)
        chk($sformatf("rnd%0d operands", cyc),
            128'({mac_a, mac_b, mac_c, mac_d, mac_e}), 128'(ops[g]));
      else
        chk($sformatf("rnd%0d operands", cyc),
            128'({mac_a, mac_b, mac_c, mac_d, mac_e}), 128'(0));
      acc = -1;
      if (g >= 0 && inr) begin
        m_vld = 1'b1;
        m_y   = mac_f(ops[g].a, ops[g].b, ops[g].c, ops[g].d, ops[g].e);
        m_ptr = g;
        m_tag = g;
        acc   = g;
      end else if (m_vld && resp_ready[m_tag]) begin
        m_vld = 1'b0;
      end
      @(posedge clk);
      #1;
      if (acc >= 0) req_valid[acc] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
